// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter that shares one FIFO write port among NUM_REQ requesters,
// granting each owner up to MAX_BURST beats before moving on.
module fifo_wr_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int BW = $clog2(MAX_BURST + 1)
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          wfull,
  output logic                          winc,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic [GW-1:0]                 grant_id,
  output logic                          busy
);

  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [GW-1:0] grant_id_q, grant_id_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;

  logic          found_s;
  logic [GW-1:0] sel_s;
  logic [GW-1:0] next_ptr_s;
  logic          owner_valid_s;
  logic          ready_s;
  logic          xfer_s;

  // State, pointer and beat-counter registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Next-state logic: arbitration in IDLE, burst accounting in GRANT
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_id_d    = grant_id_q;
    beat_cnt_d    = beat_cnt_q;
    found_s       = 1'b0;
    sel_s         = rr_ptr_q;
    owner_valid_s = req_valid[grant_id_q];
    ready_s       = (state_q == GRANT) & ~wfull & ~RST;
    xfer_s        = owner_valid_s & ready_s;
    next_ptr_s    = (grant_id_q == GW'(NUM_REQ - 1)) ? GW'(0) : grant_id_q + GW'(1);

    // Scan downward so the requester closest to rr_ptr is the last writer and wins
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sel_s   = req_valid[GW'((int'(rr_ptr_q) + k) % NUM_REQ)] ?
                GW'((int'(rr_ptr_q) + k) % NUM_REQ) : sel_s;
      found_s = found_s | req_valid[GW'((int'(rr_ptr_q) + k) % NUM_REQ)];
    end

    case (state_q)
      IDLE: begin
        if (found_s) begin
          state_d    = GRANT;
          grant_id_d = sel_s;
          beat_cnt_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (!owner_valid_s) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr_s;
        end else if (xfer_s) begin
          beat_cnt_d = beat_cnt_q + BW'(1);
          if (beat_cnt_q == BW'(MAX_BURST - 1)) begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr_s;
          end else begin
            state_d = GRANT;
          end
        end else begin
          state_d = GRANT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Write-port outputs are combinational so a beat moves in the cycle it is accepted
  always_comb begin
    req_ready             = '0;
    req_ready[grant_id_q] = ready_s;
    winc                  = xfer_s;
    wdata                 = xfer_s ? req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH] : '0;
    grant_id              = grant_id_q;
    busy                  = (state_q == GRANT);
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Randomized scoreboard bench for fifo_wr_arb against a transaction-level model.
module tb_fifo_wr_arb;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic [N-1:0]  req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          wfull;
  logic          winc;
  logic [DW-1:0] wdata;
  logic [1:0]    grant_id;
  logic          busy;

  fifo_wr_arb #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .wfull(wfull), .winc(winc), .wdata(wdata),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct { int id; int data; } wr_t;
  wr_t exp_q[$];

  int pass_cnt = 0;
  int total_cnt = 0;
  bit started = 1'b0;

  // model state: owner -1 means no grant held
  int m_owner = -1, m_beats = 0, m_rr = 0, m_gid = 0;
  int n_owner, n_beats, n_rr, n_gid;
  int m_busy, m_ready;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Evaluate one cycle of the reference model on the current inputs
  task automatic model_cycle();
    int d;
    n_owner = m_owner; n_beats = m_beats; n_rr = m_rr; n_gid = m_gid;
    m_busy  = (m_owner >= 0);
    m_ready = (m_owner >= 0 && !wfull && !RST) ? (1 << m_owner) : 0;
    if (RST) begin
      n_owner = -1; n_beats = 0; n_rr = 0; n_gid = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_rr + k) % N;
        if (req_valid[i]) begin
          n_owner = i; n_gid = i; n_beats = 0;
          break;
        end
      end
    end else if (!req_valid[m_owner]) begin
      n_owner = -1; n_rr = (m_owner + 1) % N;
    end else if (!wfull) begin
      d = int'(req_data[m_owner*DW +: DW]);
      exp_q.push_back('{id: m_owner, data: d});
      n_beats = m_beats + 1;
      if (n_beats == MB) begin
        n_owner = -1; n_rr = (m_owner + 1) % N;
      end
    end
  endtask

  // Monitor: compare DUT outputs and drain the expected-write queue
  always @(negedge CLK) begin
    if (started) begin
      chk("busy", int'(busy), m_busy);
      chk("grant_id", int'(grant_id), m_gid);
      chk("req_ready", int'(req_ready), m_ready);
      if (winc) begin
        chk("winc_while_full", int'(wfull), 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("write_id", int'(grant_id), e.id);
          chk("wdata", int'(wdata), e.data);
        end
      end else begin
        chk("wdata_idle", int'(wdata), 0);
      end
      if (exp_q.size() != 0) begin
        chk("missing_write", exp_q.size(), 0);
        exp_q.delete();
      end
    end
  end

  initial begin
    RST = 1'b1; req_valid = '0; req_data = '0; wfull = 1'b0;
    for (int cyc = 0; cyc < 1600; cyc++) begin
      @(posedge CLK);
      #1;
      if (cyc > 0) begin
        m_owner = n_owner; m_beats = n_beats; m_rr = n_rr; m_gid = n_gid;
      end
      req_data = {$urandom, $urandom};
      if (cyc < 3) begin
        RST = 1'b1; req_valid = '0; wfull = 1'b0;
      end else if (cyc < 60) begin
        RST = 1'b0; req_valid = 4'b1111; wfull = 1'b0;
      end else if (cyc < 62) begin
        RST = 1'b1; req_valid = '0; wfull = 1'b0;
      end else if (cyc < 110) begin
        RST = 1'b0; req_valid = 4'b0001; wfull = 1'b0;
      end else begin
        for (int b = 0; b < N; b++)
          if ($urandom_range(7, 0) == 0) req_valid[b] = ~req_valid[b];
        wfull = ($urandom_range(3, 0) == 0);
        RST   = ($urandom_range(79, 0) == 0);
      end
      model_cycle();
      started = 1'b1;
    end
    @(posedge CLK);
    #1;
    started = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing the FIFO write port.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, FIFO word width.
REQ-003 SHALL have parameter MAX_BURST, default 4, maximum beats written per grant (range 1..15).
REQ-004 SHALL have port CLK  input  1  write-domain clock (same clock as the FIFO write side); all logic on its rising edge.
REQ-005 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester data valid.
REQ-007 SHALL have port req_data  input  NUM_REQ*DATA_WIDTH  packed data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port req_ready  output  NUM_REQ  per-requester accept, one-hot or zero.
REQ-009 SHALL have port wfull  input  1  FIFO full flag from the write side.
REQ-010 SHALL have port winc  output  1  FIFO write strobe.
REQ-011 SHALL have port wdata  output  DATA_WIDTH  FIFO write data.
REQ-012 SHALL have port grant_id  output  clog2(NUM_REQ)  index of the current owner.
REQ-013 SHALL have port busy  output  1  high while a grant is held.

Function
REQ-014 SHALL implement a 2-state FSM: IDLE, GRANT.
REQ-015 SHALL, in IDLE with any req_valid bit high, select the first valid requester scanning upward from rr_ptr with wrap, load grant_id, clear beat_cnt, and enter GRANT next cycle.
REQ-016 SHALL perform no transfer in IDLE; arbitration latency is exactly 1 cycle from valid to the first possible transfer.
REQ-017 SHALL drive req_ready[grant_id] = (state==GRANT) & ~wfull & ~RST; all other req_ready bits 0.
REQ-018 SHALL define a transfer as req_valid[grant_id] & req_ready[grant_id]; winc equals transfer combinationally, wdata equals req_data slice of grant_id (zero latency).
REQ-019 SHALL drive wdata = 0 when winc is low.
REQ-020 SHALL increment beat_cnt on each transfer; beat_cnt width clog2(MAX_BURST+1).
REQ-021 SHALL leave GRANT for IDLE when the transfer in the current cycle makes beat_cnt reach MAX_BURST.
REQ-022 SHALL leave GRANT for IDLE when req_valid[grant_id] is low in GRANT (release, no transfer that cycle), regardless of wfull.
REQ-023 SHALL, on every GRANT->IDLE transition, load rr_ptr = (grant_id+1) mod NUM_REQ.
REQ-024 SHALL, while wfull is high in GRANT with req_valid[grant_id] high, hold state, grant_id and beat_cnt unchanged (stall, no timeout).
REQ-025 SHALL hold grant_id at its last value in IDLE; busy = (state==GRANT).
REQ-026 SHALL ignore req_valid changes of non-owners while in GRANT.
REQ-027 SHALL never assert winc while wfull is high.

Reset
REQ-028 SHALL, while RST is high at a rising edge, set state=IDLE, rr_ptr=0, beat_cnt=0, grant_id=0.
REQ-029 SHALL force winc=0, req_ready=0, wdata=0 combinationally during any cycle RST is high, including mid-burst.
REQ-030 SHALL resume with the IDLE arbitration rule on the first cycle after RST deasserts.

Verification
REQ-031 Single requester: req_valid=4'b0001 held, data 0x10..0x17, wfull=0 -> cycle 1 IDLE, 4 winc beats 0x10..0x13, 1 IDLE cycle, 4 beats 0x14..0x17.
REQ-032 Round-robin: req_valid=4'b1111 held, MAX_BURST=4 -> grant order 0,1,2,3,0 each for 4 beats separated by 1 IDLE cycle.
REQ-033 Backpressure: requester 2 granted, wfull=1 for 5 cycles after beat 2 -> winc=0 and req_ready=0 during those cycles, beat_cnt held at 2, beats 3..4 complete after wfull falls.
REQ-034 Early release: requester 1 drops req_valid after beat 1 -> IDLE next cycle, rr_ptr=2, requester 2 granted if valid.
REQ-035 Wrap: rr_ptr=3, req_valid=4'b1001 -> requester 3 granted first, then requester 0.
REQ-036 Reset mid-burst: RST=1 during beat 2 of requester 1 -> winc=0 that cycle, busy=0 next cycle, next grant goes to requester 0 if valid.
